// File: rtl/fifo_pkg.sv
// Shared helpers for fifo_flex: width derivation and error-flag bit positions.
// Benches may import this package to decode the error flags.
package fifo_pkg;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;
  localparam int ERR_W   = 2;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r++;
    end
    return r;
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer with increment enable and explicit wrap to zero.
// Works for any DEPTH, power of two or not.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_flex.sv
// Synchronous FIFO with arbitrary depth, thresholds, sticky error flags.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is registered.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 3,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      w_valid,
  input  logic [WIDTH-1:0]          data_in,
  output logic                      w_ready,
  input  logic                      r_ready,
  output logic [WIDTH-1:0]          data_out,
  output logic                      r_valid,
  output logic                      fifo_full,
  output logic                      fifo_empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   fill_count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      clr_err
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fill_q;
  logic [CNT_W-1:0] fill_d;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic [ERR_W-1:0] err_set;
  logic             push;
  logic             pop_ok;

  assign fifo_full    = (fill_q == FULL_C);
  assign fifo_empty   = (fill_q == '0);
  assign almost_full  = (fill_q >= AF_C);
  assign almost_empty = (fill_q <= AE_C);
  assign fill_count   = fill_q;
  assign w_ready      = ~fifo_full;
  assign overflow     = err_q[ERR_OVF];
  assign underflow    = err_q[ERR_UDF];

  // A pop frees a slot, so a full FIFO still takes a same-cycle write.
  assign pop_ok = r_ready & ~fifo_empty;
  assign push   = w_valid & (~fifo_full | pop_ok);

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_ok),
    .ptr   (rd_ptr)
  );

  always_comb begin
    err_set          = '0;
    err_set[ERR_OVF] = w_valid & fifo_full & ~pop_ok;
    err_set[ERR_UDF] = r_ready & fifo_empty;
    err_d            = (clr_err ? '0 : err_q) | err_set;
    fill_d           = fill_q;
    unique case (1'b1)
      push & ~pop_ok: fill_d = fill_q + CNT_W'(1);
      pop_ok & ~push: fill_d = fill_q - CNT_W'(1);
      default:        fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fill_q <= '0;
      err_q  <= '0;
    end else begin
      fill_q <= fill_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  // Empty slots are masked so data_out reads zero after reset.
  assign data_out = fifo_empty ? '0 : mem_q[rd_ptr];
  assign r_valid  = ~fifo_empty;
`else
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_d;
  logic             rv_q;
  logic             rv_d;

  always_comb begin
    dout_d = pop_ok ? mem_q[rd_ptr] : dout_q;
    rv_d   = pop_ok;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_q <= '0;
      rv_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      rv_q   <= rv_d;
    end
  end

  assign data_out = dout_q;
  assign r_valid  = rv_q;
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Random plus directed bench for fifo_flex at DEPTH=3 and DEPTH=5.
// Reference is a shift-array occupancy model; build with FIFO_FWFT_EN for FWFT mode.
module tb_fifo_flex;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_valid;
  logic [31:0] data_in;
  logic        r_ready;
  logic        clr_err;

  logic        w_ready3, r_valid3, full3, empty3, af3, ae3, ovf3, udf3;
  logic [31:0] dout3;
  logic [1:0]  fc3;
  logic        w_ready5, r_valid5, full5, empty5, af5, ae5, ovf5, udf5;
  logic [31:0] dout5;
  logic [2:0]  fc5;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_flex #(.WIDTH(32), .DEPTH(3)) u_dut3 (
    .clk(clk), .reset(reset), .w_valid(w_valid), .data_in(data_in),
    .w_ready(w_ready3), .r_ready(r_ready), .data_out(dout3),
    .r_valid(r_valid3), .fifo_full(full3), .fifo_empty(empty3),
    .almost_full(af3), .almost_empty(ae3), .fill_count(fc3),
    .overflow(ovf3), .underflow(udf3), .clr_err(clr_err)
  );

  fifo_flex #(.WIDTH(32), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut5 (
    .clk(clk), .reset(reset), .w_valid(w_valid), .data_in(data_in),
    .w_ready(w_ready5), .r_ready(r_ready), .data_out(dout5),
    .r_valid(r_valid5), .fifo_full(full5), .fifo_empty(empty5),
    .almost_full(af5), .almost_empty(ae5), .fill_count(fc5),
    .overflow(ovf5), .underflow(udf5), .clr_err(clr_err)
  );

  // Reference: words[i][0] is always the oldest entry.
  int          dep [2] = '{3, 5};
  int          afl [2] = '{2, 4};
  int          ael [2] = '{1, 1};
  logic [31:0] words [2][8];
  int          cnt [2];
  logic        m_ovf [2];
  logic        m_udf [2];
  logic        m_rv [2];
  logic [31:0] m_dout [2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    bit          pop;
    bit          psh;
    logic [31:0] head;
    if (!reset) begin
      cnt[i]    = 0;
      m_ovf[i]  = 1'b0;
      m_udf[i]  = 1'b0;
      m_rv[i]   = 1'b0;
      m_dout[i] = '0;
      return;
    end
    pop  = r_ready && cnt[i] > 0;
    psh  = w_valid && (cnt[i] < dep[i] || pop);
    head = words[i][0];
    if (clr_err) begin
      m_ovf[i] = 1'b0;
      m_udf[i] = 1'b0;
    end
    if (w_valid && cnt[i] == dep[i] && !pop) m_ovf[i] = 1'b1;
    if (r_ready && cnt[i] == 0) m_udf[i] = 1'b1;
    if (pop) begin
      for (int k = 0; k < 7; k++) words[i][k] = words[i][k+1];
      cnt[i]--;
    end
    if (psh) begin
      words[i][cnt[i]] = data_in;
      cnt[i]++;
    end
    m_rv[i] = pop;
    if (pop) m_dout[i] = head;
  endtask

  function automatic logic [31:0] exp_dout(input int i);
`ifdef FIFO_FWFT_EN
    return (cnt[i] > 0) ? words[i][0] : 32'h0;
`else
    return m_dout[i];
`endif
  endfunction

  function automatic logic exp_rv(input int i);
`ifdef FIFO_FWFT_EN
    return cnt[i] > 0;
`else
    return m_rv[i];
`endif
  endfunction

  task automatic check_all();
    chk("d3_count", 32'(fc3), 32'(cnt[0]));
    chk("d3_full",  32'(full3), 32'(cnt[0] == 3));
    chk("d3_empty", 32'(empty3), 32'(cnt[0] == 0));
    chk("d3_wrdy",  32'(w_ready3), 32'(cnt[0] != 3));
    chk("d3_af",    32'(af3), 32'(cnt[0] >= afl[0]));
    chk("d3_ae",    32'(ae3), 32'(cnt[0] <= ael[0]));
    chk("d3_ovf",   32'(ovf3), 32'(m_ovf[0]));
    chk("d3_udf",   32'(udf3), 32'(m_udf[0]));
    chk("d3_rv",    32'(r_valid3), 32'(exp_rv(0)));
    chk("d3_dout",  dout3, exp_dout(0));
    chk("d5_count", 32'(fc5), 32'(cnt[1]));
    chk("d5_full",  32'(full5), 32'(cnt[1] == 5));
    chk("d5_empty", 32'(empty5), 32'(cnt[1] == 0));
    chk("d5_wrdy",  32'(w_ready5), 32'(cnt[1] != 5));
    chk("d5_af",    32'(af5), 32'(cnt[1] >= afl[1]));
    chk("d5_ae",    32'(ae5), 32'(cnt[1] <= ael[1]));
    chk("d5_ovf",   32'(ovf5), 32'(m_ovf[1]));
    chk("d5_udf",   32'(udf5), 32'(m_udf[1]));
    chk("d5_rv",    32'(r_valid5), 32'(exp_rv(1)));
    chk("d5_dout",  dout5, exp_dout(1));
  endtask

  task automatic cyc(input logic wv, input logic [31:0] d,
                     input logic rr, input logic clr);
    @(negedge clk);
    w_valid = wv;
    data_in = d;
    r_ready = rr;
    clr_err = clr;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  initial begin
    reset   = 1'b0;
    w_valid = 1'b0;
    data_in = '0;
    r_ready = 1'b0;
    clr_err = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(1, 32'h77, 1, 0);
    chk("rst_empty", 32'(empty3), 32'd1);
    chk("rst_full",  32'(full3), 32'd0);
    chk("rst_count", 32'(fc3), 32'd0);
    chk("rst_rv",    32'(r_valid3), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) cyc(1, 32'(i), 0, 0);
    chk("full_count", 32'(fc3), 32'd3);
    chk("full_ovf",   32'(ovf3), 32'd1);
    chk("af5_at4",    32'(af5), 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    chk("drained", 32'(empty3), 32'd1);

    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 32'(8'hB0 + i), 0, 0);
    cyc(1, 32'hA5, 1, 0);
    chk("pp_count", 32'(fc3), 32'd3);
    chk("pp_ovf",   32'(ovf3), 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("udf_set", 32'(udf3), 32'd1);
    cyc(0, 0, 0, 1);
    chk("udf_clr", 32'(udf3), 32'd0);
    cyc(0, 0, 1, 1);
    chk("udf_set_wins", 32'(udf3), 32'd1);
    cyc(1, 32'h55, 1, 1);

    cyc(0, 0, 1, 0);
    cyc(1, 32'h10, 0, 0);
    for (int i = 1; i < 10; i++) cyc(1, 32'(8'h10 + i), 1, 0);
    cyc(0, 0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      int pw;
      int pr;
      pw = ((i / 200) % 2 == 0) ? 75 : 35;
      pr = 100 - pw;
      if ($urandom_range(0, 99) == 0) reset = 1'b0;
      else reset = 1'b1;
      cyc($urandom_range(0, 99) < pw, $urandom,
          $urandom_range(0, 99) < pr, $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
